add_sequencer: RTL and testbench

ADD_SEQUENCER -- requirements
Module: add_sequencer

---
 rtl/add_sequencer.sv | 117 +++++++++++
 tb/tb_add_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/add_sequencer.sv
// 32-bit add/subtract unit built from one 8-bit adder slice used over four
// cycles, LSB slice first, with a valid/ready handshake on both sides.
module add_sequencer (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        c_out,
    output logic        ovf,
    input  logic        flush
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_idx;
    logic [31:0] r_x;
    logic [31:0] r_yeff;
    logic        r_carry;
    logic [31:0] r_result;
    logic        r_cout;
    logic        r_ovf;

    logic        w_accept;
    logic [7:0]  w_a;
    logic [7:0]  w_b;
    logic [8:0]  w_sum;

    // The y operand is stored already inverted for subtraction, so the slice
    // adder only ever adds; the +1 arrives through the initial carry.
    always_comb begin
        w_a   = r_x[{r_idx, 3'b000} +: 8];
        w_b   = r_yeff[{r_idx, 3'b000} +: 8];
        w_sum = {1'b0, w_a} + {1'b0, w_b} + {8'b0, r_carry};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_state_nxt = RUN;
                    w_accept    = 1'b1;
                end
            end
            RUN: begin
                if (r_idx == 2'd3) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (flush) begin
            w_state_nxt = IDLE;
            w_accept    = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_idx    <= '0;
            r_x      <= '0;
            r_yeff   <= '0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (flush) begin
            r_idx <= '0;
        end else if (w_accept) begin
            r_x     <= x;
            r_yeff  <= sub ? ~y : y;
            r_carry <= sub;
            r_idx   <= '0;
        end else if (r_state == RUN) begin
            r_result[{r_idx, 3'b000} +: 8] <= w_sum[7:0];
            r_carry <= w_sum[8];
            r_idx   <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
                r_cout <= w_sum[8];
                r_ovf  <= (w_a[7] == w_b[7]) && (w_sum[7] != w_a[7]);
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;
    assign c_out     = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_add_sequencer.sv
// Self-checking bench for add_sequencer: directed corner vectors, backpressure,
// flush and asynchronous reset, then randomized operations against a model.
module tb_add_sequencer;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic [31:0] y;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        c_out;
    logic        ovf;
    logic        flush;

    int total;
    int bad;

    logic [31:0] exp_r;
    logic        exp_c;
    logic        exp_o;

    add_sequencer dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .c_out     (c_out),
        .ovf       (ovf),
        .flush     (flush)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, expv);
            $error("check %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: exact integer arithmetic, then reduce to 32 bits.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] r, output logic c, output logic o);
        longint          sa;
        longint          sb;
        longint          sr;
        longint unsigned ua;
        longint unsigned ub;
        logic signed [31:0] rs;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        if (s) begin
            sr = sa - sb;
            r  = a - b;
            c  = (ua >= ub);
        end else begin
            sr = sa + sb;
            r  = a + b;
            c  = ((ua + ub) >> 32) != 0;
        end
        rs = r;
        o  = (sr != rs);
    endfunction

    task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic s);
        check("in_ready_before_accept", in_ready, 1);
        x = a;
        y = b;
        sub = s;
        in_valid = 1'b1;
        model(a, b, s, exp_r, exp_c, exp_o);
        tick();
        in_valid = 1'b0;
        x = $urandom;
        y = $urandom;
        sub = 1'($urandom);
    endtask

    task automatic wait_result();
        int n;
        n = 0;
        while (!out_valid && n < 10) begin
            check("in_ready_busy", in_ready, 0);
            tick();
            n++;
        end
        check("latency", n, 4);
        check("result", result, exp_r);
        check("c_out", c_out, exp_c);
        check("ovf", ovf, exp_o);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input int hold);
        accept(a, b, s);
        wait_result();
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            x = $urandom;
            y = $urandom;
            sub = 1'($urandom);
            tick();
            check("hold_valid", out_valid, 1);
            check("hold_ready", in_ready, 0);
            check("hold_result", result, exp_r);
            check("hold_cout", c_out, exp_c);
            check("hold_ovf", ovf, exp_o);
        end
        // in_valid high on the consume edge must not start a new operation
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid = 1'b0;
        check("consume_valid", out_valid, 0);
        check("consume_ready", in_ready, 1);
        check("idle_result_kept", result, exp_r);
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        flush = 1'b0;
        x = '0;
        y = '0;
        sub = 1'b0;
        #3;
        check("rst_result", result, 0);
        check("rst_cout", c_out, 0);
        check("rst_ovf", ovf, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        #20;
        reset_n = 1'b1;

        run_op(32'h000000FF, 32'h00000001, 1'b0, 0);
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1);
        check("vec_wrap_c", c_out, 1);
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 0);
        check("vec_ovf_add", ovf, 1);
        run_op(32'h00000005, 32'h00000007, 1'b1, 0);
        check("vec_sub_r", result, 32'hFFFFFFFE);
        run_op(32'h80000000, 32'h00000001, 1'b1, 0);
        check("vec_sub_ovf", ovf, 1);
        check("vec_sub_c", c_out, 1);
        run_op(32'h000000FF, 32'h00000001, 1'b0, 10);
        check("vec_bp_r", result, 32'h00000100);

        // flush at slice index 2
        accept(32'h12345678, 32'h11111111, 1'b0);
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_run_ready", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("flush_run_no_valid", out_valid, 0);
        end

        // flush outranks a simultaneous accept
        in_valid = 1'b1;
        x = 32'h1;
        y = 32'h2;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_accept_ready", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("flush_accept_no_valid", out_valid, 0);
        end

        // flush in DONE with out_ready low
        accept(32'hDEADBEEF, 32'h01010101, 1'b1);
        wait_result();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_done_valid", out_valid, 0);
        check("flush_done_ready", in_ready, 1);

        // asynchronous reset in the middle of an operation
        accept(32'hCAFEF00D, 32'h0F0F0F0F, 1'b0);
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_result", result, 0);
        check("arst_cout", c_out, 0);
        check("arst_ovf", ovf, 0);
        check("arst_valid", out_valid, 0);
        check("arst_ready", in_ready, 1);
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("arst_no_valid", out_valid, 0);
        end

        for (int i = 0; i < 4000; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                in_valid = 1'b0;
                tick();
                check("gap_no_valid", out_valid, 0);
            end
            run_op($urandom, $urandom, 1'($urandom), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
